spi_byte_master: RTL

- SPI mode-0 (CPOL=0, CPHA=0), MSB-first, single-byte transfer engine for the SpeedSPI path.
- Accepts a byte on a start/busy handshake, drives sclk/mosi/cs_n, captures miso, and returns the received byte.
- Emits a one-cycle `done` pulse that feeds the downstream interrupt delay stage's `in_irq`, directly upstream of it.
- Chip select can be held across consecutive bytes for burst transactions.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_byte_master_if.sv | 41 ++++
 rtl/spi_phase_timer.sv | 36 +++
 rtl/spi_byte_master.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and constants for the SPI byte master
//
// Purpose: state enumeration and sizing constants used by spi_byte_master
// and its helpers.
// Ports: none (package).

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    localparam int SPI_BITS        = 8;
    localparam int CLK_DIV_DEFAULT = 4;

endpackage : spi_pkg

// File: rtl/spi_byte_master_if.sv
// rtl/spi_byte_master_if.sv - host-side request/response bundle for the SPI byte master
//
// Purpose: groups the start/busy handshake, the data bytes and the done pulse.
// Ports (signals):
//   start    host -> master  transfer request
//   tx_data  host -> master  byte to send
//   hold_cs  host -> master  keep cs_n low after this byte
//   busy     master -> host  transfer in progress
//   rx_data  master -> host  last received byte
//   done     master -> host  one-cycle completion pulse
// Modports: master = host side, slave = spi_byte_master side.

interface spi_byte_master_if;
    import spi_pkg::*;

    logic                start;
    logic [SPI_BITS-1:0] tx_data;
    logic                hold_cs;
    logic                busy;
    logic [SPI_BITS-1:0] rx_data;
    logic                done;

    modport master (
        output start,
        output tx_data,
        output hold_cs,
        input  busy,
        input  rx_data,
        input  done
    );

    modport slave (
        input  start,
        input  tx_data,
        input  hold_cs,
        output busy,
        output rx_data,
        output done
    );

endinterface : spi_byte_master_if

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - half-period phase counter with clear and terminal count
//
// Purpose: counts clk cycles inside one FSM state; tc flags the last cycle.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   clear  in   force the count back to 0 on the next edge
//   tc     out  high while count == CLK_DIV-1

module spi_phase_timer #(
    parameter int DIV_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam logic [DIV_W-1:0] TC_VAL = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule : spi_phase_timer

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - SPI mode-0 MSB-first single-byte transfer engine
//
// Purpose: accepts a byte on start, shifts it out on mosi while sampling miso,
// returns the received byte and pulses done. cs_n may be held across bytes.
// Ports:
//   clk   in   system clock (rising edge)
//   rst   in   asynchronous active-low reset
//   bus   slave modport of spi_byte_master_if (start/tx_data/hold_cs in,
//         busy/rx_data/done out)
//   sclk  out  SPI clock, idles 0
//   mosi  out  SPI data out
//   miso  in   SPI data in, synchronous to clk
//   cs_n  out  chip select, active-low

module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_byte_master_if.slave   bus,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_n
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_t          state, state_nx;
    logic                tc;
    logic                clear;

    logic [SPI_BITS-1:0] tx_sr, tx_sr_d;
    logic [SPI_BITS-1:0] rx_sr, rx_sr_d;
    logic [2:0]          bit_cnt, bit_cnt_d;
    logic                hold_q, hold_d;
    logic                sclk_d, mosi_d, cs_n_d, busy_q, busy_d, done_q, done_d;
    logic [SPI_BITS-1:0] rx_q, rx_d;

    // Phase count restarts on every state change and stays parked in IDLE.
    assign clear = (state_nx != state) || (state == ST_IDLE);

    spi_phase_timer #(
        .DIV_W   (DIV_W),
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            hold_q  <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            state   <= state_nx;
            tx_sr   <= tx_sr_d;
            rx_sr   <= rx_sr_d;
            bit_cnt <= bit_cnt_d;
            hold_q  <= hold_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            cs_n    <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        state_nx  = state;
        tx_sr_d   = tx_sr;
        rx_sr_d   = rx_sr;
        bit_cnt_d = bit_cnt;
        hold_d    = hold_q;
        sclk_d    = sclk;
        mosi_d    = mosi;
        cs_n_d    = cs_n;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_d      = rx_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx  = ST_SETUP;
                    tx_sr_d   = bus.tx_data;
                    hold_d    = bus.hold_cs;
                    cs_n_d    = 1'b0;
                    mosi_d    = bus.tx_data[SPI_BITS-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (tc) begin
                    state_nx = ST_HIGH;
                    sclk_d   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    // Sample at the falling edge, then present the next bit
                    // for the LOW half-period.
                    state_nx = ST_LOW;
                    sclk_d   = 1'b0;
                    rx_sr_d  = {rx_sr[SPI_BITS-2:0], miso};
                    tx_sr_d  = {tx_sr[SPI_BITS-2:0], 1'b0};
                    mosi_d   = tx_sr[SPI_BITS-2];
                end
            end
            ST_LOW: begin
                // The final bit also gets a full LOW half-period before DONE,
                // giving the slave hold time after the last falling edge and
                // a byte length of 17 half-periods including setup.
                if (tc) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = ST_DONE;
                        done_d   = 1'b1;
                        rx_d     = rx_sr;
                    end else begin
                        state_nx  = ST_HIGH;
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                busy_d   = 1'b0;
                mosi_d   = 1'b0;
                cs_n_d   = ~hold_q;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

endmodule : spi_byte_master
